// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the execute-stage arithmetic blocks.
//   - div_state_e   : divider control states (IDLE / CALC / FINISH)
//   - DIV_WIDTH     : operand / quotient / remainder width of the divider
//   - DIV_ZERO_QUOT : quotient returned when the divisor is zero (all ones)
package alu_pkg;

  localparam int DIV_WIDTH = 16;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = {DIV_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CALC   = 2'd1,
    ST_FINISH = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational iteration of a restoring divider.
//   rem_i  : partial remainder entering the iteration
//   dvd_i  : remaining dividend magnitude bits; quotient bits shift in at the LSB
//   dsr_i  : divisor magnitude
//   rem_o  : partial remainder after trial subtract / restore
//   dvd_o  : dvd_i shifted left one place with the new quotient bit in the LSB
module div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] dvd_i,
  input  logic [WIDTH-1:0] dsr_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] dvd_o
);

  // Upper half of {rem, dvd} << 1, kept WIDTH+1 bits so the bit shifted out of
  // the remainder is not lost when the divisor magnitude exceeds 2^(WIDTH-1).
  logic [WIDTH:0] upper_s;
  logic [WIDTH:0] trial_s;

  assign upper_s = {rem_i, dvd_i[WIDTH-1]};
  // rem_i < dsr_i always holds, so the difference fits in WIDTH+1 signed bits
  // and its MSB is a reliable borrow indicator.
  assign trial_s = upper_s - {1'b0, dsr_i};

  // Accept the trial result when it did not go negative, otherwise restore.
  always_comb begin
    if (trial_s[WIDTH]) begin
      rem_o = upper_s[WIDTH-1:0];
      dvd_o = {dvd_i[WIDTH-2:0], 1'b0};
    end else begin
      rem_o = trial_s[WIDTH-1:0];
      dvd_o = {dvd_i[WIDTH-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/alu_divider.sv
// alu_divider: multi-cycle restoring divider, one quotient bit per cycle.
//   clk, reset        : clock and synchronous active-high reset
//   start             : request a division (sampled only while idle)
//   is_signed         : 1 = two's-complement, 0 = unsigned (sampled with start)
//   dividend, divisor : operands (sampled with start)
//   busy              : operation in progress
//   done              : one-cycle pulse when a new result is presented
//   quotient          : result quotient, held until the next done
//   remainder         : result remainder, held until the next done
//   div_by_zero       : set when the held result came from a zero divisor
// Latency is WIDTH+1 cycles from the accepting edge; a zero divisor
// completes after one cycle.
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [WIDTH-1:0] ONE_W  = WIDTH'(1);

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    return ~v + ONE_W;
  endfunction

  div_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] rem_q, rem_d;      // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;      // dividend magnitude, becomes quotient
  logic [WIDTH-1:0] dsr_q, dsr_d;      // divisor magnitude
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             dz_q, dz_d;        // zero divisor for the operation in flight
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;

  logic [WIDTH-1:0] step_rem_s;
  logic [WIDTH-1:0] step_dvd_s;
  logic             dvd_sign_s;
  logic             dsr_sign_s;

  assign dvd_sign_s = is_signed & dividend[WIDTH-1];
  assign dsr_sign_s = is_signed & divisor[WIDTH-1];

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .dvd_i (dvd_q),
    .dsr_i (dsr_q),
    .rem_o (step_rem_s),
    .dvd_o (step_dvd_s)
  );

  // Next-state and datapath logic for the IDLE -> CALC -> FINISH sequence.
  always_comb begin
    state_d       = state_q;
    count_d       = count_q;
    rem_d         = rem_q;
    dvd_d         = dvd_q;
    dsr_d         = dsr_q;
    q_neg_d       = q_neg_q;
    r_neg_d       = r_neg_q;
    dz_d          = dz_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          busy_d  = 1'b1;
          count_d = {CW{1'b0}};
          if (divisor == {WIDTH{1'b0}}) begin
            // Preload the fixed zero-divisor result; sign fixup is disabled
            // so FINISH passes it through untouched.
            dvd_d   = DIV_ZERO_QUOT;
            rem_d   = dividend;
            dsr_d   = divisor;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            dz_d    = 1'b1;
            state_d = ST_FINISH;
          end else begin
            dvd_d   = dvd_sign_s ? negate(dividend) : dividend;
            dsr_d   = dsr_sign_s ? negate(divisor) : divisor;
            rem_d   = {WIDTH{1'b0}};
            q_neg_d = dvd_sign_s ^ dsr_sign_s;
            r_neg_d = dvd_sign_s;
            dz_d    = 1'b0;
            state_d = ST_CALC;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_CALC: begin
        rem_d   = step_rem_s;
        dvd_d   = step_dvd_s;
        count_d = count_q + CNT_ONE;
        if (count_q == LAST_ITER) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_CALC;
        end
      end

      ST_FINISH: begin
        quotient_d    = q_neg_q ? negate(dvd_q) : dvd_q;
        remainder_d   = r_neg_q ? negate(rem_q) : rem_q;
        div_by_zero_d = dz_q;
        done_d        = 1'b1;
        busy_d        = 1'b0;
        state_d       = ST_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      count_q       <= {CW{1'b0}};
      rem_q         <= {WIDTH{1'b0}};
      dvd_q         <= {WIDTH{1'b0}};
      dsr_q         <= {WIDTH{1'b0}};
      q_neg_q       <= 1'b0;
      r_neg_q       <= 1'b0;
      dz_q          <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      quotient_q    <= {WIDTH{1'b0}};
      remainder_q   <= {WIDTH{1'b0}};
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      rem_q         <= rem_d;
      dvd_q         <= dvd_d;
      dsr_q         <= dsr_d;
      q_neg_q       <= q_neg_d;
      r_neg_q       <= r_neg_d;
      dz_q          <= dz_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule
